// File: rtl/wb_commit_arb.sv
// rtl/wb_commit_arb.sv - writeback commit arbiter; define WB_RR_EN for round-robin, else fixed priority
module wb_commit_arb #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [5*NUM_SRC-1:0]    src_rd_addr,
  input  logic [XLEN*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic                    wb_stall,
  output logic                    RegWrite,
  output logic [4:0]              rd_addr,
  output logic [XLEN-1:0]         rd_data,
  output logic [31:0]             commit_cnt
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_any;
  logic               w_commit;
  logic [4:0]         w_sel_addr;
  logic [XLEN-1:0]    w_sel_data;

  logic               r_wr;
  logic [4:0]         r_rd_addr;
  logic [XLEN-1:0]    r_rd_data;
  logic [31:0]        r_commit_cnt;

  // Requests are masked while the register-file port is busy or reset is held
  assign w_req = src_valid & {NUM_SRC{~wb_stall & rst_n}};

`ifdef WB_RR_EN
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;
  int            w_idx;

  // Round-robin grant: scan from the pointer, wrapping, first requester wins
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      if (!w_found && w_req[w_idx]) begin
        w_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  // Priority moves to the channel just after the one granted
  always_comb begin
    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt[i]) w_ptr_nxt = (i == NUM_SRC - 1) ? '0 : PW'(i + 1);
    end
  end

  // Pointer only advances on a completed handshake, so a stall leaves it put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end
`else
  logic w_found;

  // Fixed priority grant: lowest valid index wins
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!w_found && w_req[i]) begin
        w_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

  assign w_any     = |w_gnt;
  assign src_ready = w_gnt;

  // One-hot mux of the granted channel's destination and data
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = src_rd_addr[5*i +: 5];
        w_sel_data = src_data[XLEN*i +: XLEN];
      end
    end
  end

  // Writes to x0 are accepted but never reach the register file
  assign w_commit = w_any && (w_sel_addr != 5'd0);

  // Writeback stage register and commit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr         <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_data    <= '0;
      r_commit_cnt <= '0;
    end else begin
      r_wr <= w_commit;
      if (w_any) begin
        r_rd_addr <= w_sel_addr;
        r_rd_data <= w_sel_data;
      end
      if (w_commit) r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  assign RegWrite   = r_wr;
  assign rd_addr    = r_rd_addr;
  assign rd_data    = r_rd_data;
  assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_wb_commit_arb.sv
// tb/tb_wb_commit_arb.sv - directed self-checking bench for wb_commit_arb
module tb_wb_commit_arb;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_SRC-1:0]      src_valid;
  logic [5*NUM_SRC-1:0]    src_rd_addr;
  logic [XLEN*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]      src_ready;
  logic                    wb_stall;
  logic                    RegWrite;
  logic [4:0]              rd_addr;
  logic [XLEN-1:0]         rd_data;
  logic [31:0]             commit_cnt;

  int n_total;
  int n_bad;
  logic [31:0] exp_cnt;
  logic [1:0]  exp_rdy [4];
  logic [4:0]  exp_rd  [4];

  wb_commit_arb #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_rd_addr (src_rd_addr),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .wb_stall    (wb_stall),
    .RegWrite    (RegWrite),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .commit_cnt  (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    src_valid   = v;
    src_rd_addr = {a1, a0};
    src_data    = {d1, d0};
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    wb_stall = 1'b0;
    drive(2'b11, 5'd3, 32'h11, 5'd4, 32'h22);
    exp_cnt = 32'd0;

    // reset state: no grants, outputs cleared
    #12;
    chk("rst_ready", src_ready, 2'b00);
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_cnt", commit_cnt, 32'd0);

    // single write on ch0; first grant in first cycle out of reset
    tick();
    rst_n = 1'b1;
    drive(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0);
    #1;
    chk("single_ready", src_ready, 2'b01);
    tick();
    drive(2'b00, 5'd9, 32'h9999, 5'd9, 32'h9999);
    exp_cnt++;
    chk("single_regwrite", RegWrite, 1'b1);
    chk("single_rd_addr", rd_addr, 5'd5);
    chk("single_rd_data", rd_data, 32'h00001234);
    chk("single_cnt", commit_cnt, exp_cnt);
    #1;
    chk("idle_ready", src_ready, 2'b00);

    // idle cycle: no write, address/data hold
    tick();
    chk("idle_regwrite", RegWrite, 1'b0);
    chk("idle_rd_addr", rd_addr, 5'd5);
    chk("idle_rd_data", rd_data, 32'h00001234);
    chk("idle_cnt", commit_cnt, exp_cnt);

    // reset to put the pointer back at 0 before the contention test
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 32'd0;

`ifdef WB_RR_EN
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd  = '{5'd1, 5'd2, 5'd1, 5'd2};
`else
    exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_rd  = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
    // both channels valid for four cycles
    drive(2'b11, 5'd1, 32'hA0, 5'd2, 32'hB1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("contend_ready%0d", i), src_ready, exp_rdy[i]);
      tick();
      exp_cnt++;
      chk($sformatf("contend_rd%0d", i), rd_addr, exp_rd[i]);
      chk($sformatf("contend_data%0d", i), rd_data, (exp_rd[i] == 5'd1) ? 32'hA0 : 32'hB1);
      chk($sformatf("contend_cnt%0d", i), commit_cnt, exp_cnt);
    end

    // x0 destination on ch1: handshake completes, no write
    drive(2'b10, 5'd7, 32'h0, 5'd0, 32'hDEAD);
    #1;
    chk("x0_ready", src_ready, 2'b10);
    tick();
    chk("x0_regwrite", RegWrite, 1'b0);
    chk("x0_cnt", commit_cnt, exp_cnt);

    // stall for three cycles with ch0 valid
    wb_stall = 1'b1;
    drive(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_ready%0d", i), src_ready, 2'b00);
      tick();
      chk($sformatf("stall_regwrite%0d", i), RegWrite, 1'b0);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_ready", src_ready, 2'b01);
    tick();
    exp_cnt++;
    chk("unstall_regwrite", RegWrite, 1'b1);
    chk("unstall_rd_addr", rd_addr, 5'd6);
    chk("unstall_cnt", commit_cnt, exp_cnt);

    // handshake on ch1, then reset before the next edge discards the write
    drive(2'b10, 5'd0, 32'h0, 5'd7, 32'h77);
    tick();
    chk("prerst_regwrite", RegWrite, 1'b1);
    rst_n = 1'b0;
    drive(2'b11, 5'd8, 32'h88, 5'd9, 32'h99);
    #1;
    chk("async_regwrite", RegWrite, 1'b0);
    chk("async_cnt", commit_cnt, 32'd0);
    chk("async_ready", src_ready, 2'b00);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", src_ready, 2'b01);
    tick();
    chk("post_rst_rd_addr", rd_addr, 5'd8);

    // counter wrap
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    force dut.r_commit_cnt = 32'hFFFFFFFF;
    #1;
    release dut.r_commit_cnt;
    drive(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
    tick();
    chk("wrap_regwrite", RegWrite, 1'b1);
    chk("wrap_cnt", commit_cnt, 32'h00000000);

    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_commit_arb.md
WB_COMMIT_ARB -- requirements
Module: wb_commit_arb

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter NUM_SRC, default 2, number of result channels (legal 1..4).
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port src_valid  in  NUM_SRC  per-channel result valid.
REQ-006 Port src_rd_addr  in  5*NUM_SRC  per-channel destination register; channel i at bits [5i+4:5i].
REQ-007 Port src_data  in  XLEN*NUM_SRC  per-channel result; channel i at bits [XLEN*i+XLEN-1:XLEN*i].
REQ-008 Port src_ready  out  NUM_SRC  per-channel accept; one-hot or zero.
REQ-009 Port wb_stall  in  1  register-file port unavailable this cycle.
REQ-010 Port RegWrite  out  1  register-file write enable (registered).
REQ-011 Port rd_addr  out  5  register-file write address (registered).
REQ-012 Port rd_data  out  XLEN  register-file write data (registered).
REQ-013 Port commit_cnt  out  32  count of RegWrite pulses.

Function
REQ-014 Handshake on channel i SHALL complete in the cycle where src_valid[i] and src_ready[i] are both 1.
REQ-015 src_ready SHALL be combinational: exactly the granted channel; all zero when no channel is valid or wb_stall=1.
REQ-016 src_ready[i] SHALL never be 1 while src_valid[i]=0.
REQ-017 Latency: a handshake in cycle N SHALL drive RegWrite/rd_addr/rd_data with that channel's values in cycle N+1 only.
REQ-018 With no handshake in cycle N, RegWrite SHALL be 0 in cycle N+1; rd_addr/rd_data hold previous values.
REQ-019 A handshake with rd_addr 0 SHALL complete normally but produce RegWrite=0 next cycle (x0 suppression).
REQ-020 wb_stall=1 SHALL block all grants and leave the arbitration pointer unchanged.
REQ-021 A valid channel not granted SHALL keep its request; the block holds no copy of unaccepted data.
REQ-022 commit_cnt SHALL increment by 1 in each cycle RegWrite is registered 1; wraps 0xFFFFFFFF -> 0.
REQ-023 NUM_SRC=1: channel 0 SHALL be granted whenever valid and wb_stall=0.

Reset
REQ-024 rst_n low SHALL asynchronously clear RegWrite, rd_addr, rd_data, commit_cnt and arbitration pointer to 0.
REQ-025 During reset src_ready SHALL be all zero; first grant possible in first cycle rst_n is high.
REQ-026 Reset asserted mid-operation SHALL discard the registered pending write (RegWrite 0 immediately).

Configuration
REQ-027 Macro WB_RR_EN defined: round-robin; after granting channel i, highest priority moves to (i+1) mod NUM_SRC; pointer starts at 0.
REQ-028 WB_RR_EN undefined: fixed priority, lowest valid index wins; pointer logic absent.

Verification
REQ-029 NUM_SRC=2, ch0 valid rd=5 data=0x1234 for 1 cycle -> src_ready=01 same cycle; next cycle RegWrite=1 rd_addr=5 rd_data=0x00001234, commit_cnt=1.
REQ-030 Both channels valid 4 cycles (ch0 rd=1, ch1 rd=2), WB_RR_EN -> grants 0,1,0,1; without WB_RR_EN -> grants 0,0,0,0.
REQ-031 ch1 valid rd=0 data=0xDEAD -> src_ready=10, next cycle RegWrite=0, commit_cnt unchanged.
REQ-032 wb_stall=1 for 3 cycles with ch0 valid -> src_ready=00 throughout, RegWrite=0; stall drops -> grant ch0 that cycle, write next.
REQ-033 Handshake then rst_n low before next edge -> RegWrite=0, commit_cnt=0 asynchronously; after release, pointer 0 grants ch0 first.
REQ-034 Force commit_cnt to 0xFFFFFFFF, one committed write -> commit_cnt=0x00000000.
